cga_line_doubler: RTL and testbench



---
 rtl/cga_line_doubler.sv | 122 ++++++++++++
 tb/tb_cga_line_doubler.sv | 117 +++++++++++
 2 files changed

// File: rtl/cga_line_doubler.sv
// CGA scan doubler: captures each input line into a ping-pong buffer and replays it twice at 2x pixel rate.
// Optional CGA_DBL_SCANLINE_EN dims the second replay by clearing the intensity bit.
module cga_line_doubler #(
   parameter int LINE_PIXELS = 1024,
   parameter int IN_DIV      = 4,
   parameter int HS_START    = 20,
   parameter int HS_WIDTH    = 54
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       line_reset,
   input  logic [3:0] video,
   output logic [3:0] dbl_video,
   output logic       dbl_hsync
);
   localparam int AW     = $clog2(LINE_PIXELS);
   localparam int CW     = (AW + 1 > 11) ? AW + 1 : 11;
   localparam int HALF   = IN_DIV / 2;
   localparam int PW_IN  = $clog2(IN_DIV);
   localparam int PW_OUT = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HS_LO = CW'(HS_START);
   localparam logic [CW-1:0] HS_HI = CW'(HS_START + HS_WIDTH);

   typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

   logic [3:0]        mem [2*LINE_PIXELS];
   logic [3:0]        rdata;
   logic              wbank, armed;
   logic [CW-1:0]     len_q, wcount, ocount, ocount_nx;
   logic [PW_IN-1:0]  in_phase;
   logic [PW_OUT-1:0] out_phase, out_phase_nx;
   state_t            state, state_nx;
   logic              we;
   logic [AW:0]       waddr, raddr;
   logic              s1_vld, s1_hs, s1_p1;

   // Capture is held off until the first line_reset so a partial line is never replayed.
   assign we    = ~reset & (line_reset | (armed & (in_phase == '0) & ~wcount[AW]));
   assign waddr = line_reset ? {~wbank, {AW{1'b0}}} : {wbank, wcount[AW-1:0]};
   assign raddr = {~wbank, ocount[AW-1:0]};

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= video;
      rdata <= mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wbank    <= 1'b0;
         armed    <= 1'b0;
         len_q    <= '0;
         wcount   <= '0;
         in_phase <= '0;
      end else if (line_reset) begin
         wbank    <= ~wbank;
         armed    <= 1'b1;
         len_q    <= wcount;
         wcount   <= CW'(1);
         in_phase <= PW_IN'(1);
      end else begin
         in_phase <= (in_phase == PW_IN'(IN_DIV - 1)) ? '0 : in_phase + PW_IN'(1);
         if (armed && in_phase == '0 && !wcount[AW]) wcount <= wcount + CW'(1);
      end
   end

   always_comb begin
      state_nx     = state;
      ocount_nx    = ocount;
      out_phase_nx = (out_phase == PW_OUT'(HALF - 1)) ? '0 : out_phase + PW_OUT'(1);
      if (line_reset) begin
         // The new replay length is the wcount being latched this cycle.
         state_nx     = (wcount == '0) ? IDLE : PASS0;
         ocount_nx    = '0;
         out_phase_nx = PW_OUT'(1 % HALF);
      end else if (out_phase == '0 && state != IDLE) begin
         if (ocount == len_q - CW'(1)) begin
            state_nx  = (state == PASS0) ? PASS1 : IDLE;
            ocount_nx = '0;
         end else begin
            ocount_nx = ocount + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ocount    <= '0;
         out_phase <= '0;
      end else begin
         state     <= state_nx;
         ocount    <= ocount_nx;
         out_phase <= out_phase_nx;
      end
   end

   // Stage 1 runs alongside the RAM read, stage 2 is the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld    <= 1'b0;
         s1_hs     <= 1'b0;
         s1_p1     <= 1'b0;
         dbl_video <= '0;
         dbl_hsync <= 1'b0;
      end else begin
         s1_vld    <= (state != IDLE);
         s1_hs     <= (state != IDLE) && (ocount >= HS_LO) && (ocount < HS_HI);
         s1_p1     <= (state == PASS1);
`ifdef CGA_DBL_SCANLINE_EN
         dbl_video <= !s1_vld ? 4'h0 : (s1_p1 ? {1'b0, rdata[2:0]} : rdata);
`else
         dbl_video <= s1_vld ? rdata : 4'h0;
`endif
         dbl_hsync <= s1_hs;
      end
   end

`ifndef CGA_DBL_SCANLINE_EN
   logic unused_p1;
   assign unused_p1 = s1_p1;
`endif
endmodule

// File: tb/tb_cga_line_doubler.sv
// Scoreboard bench for cga_line_doubler: a closed-form replay model queues expected outputs, compared 2 clk later.
module tb_cga_line_doubler;
   localparam int LP   = 1024;
   localparam int DIV  = 4;
   localparam int HALF = DIV / 2;
   localparam int HSS  = 20;
   localparam int HSW  = 54;

   logic       clk = 1'b0;
   logic       reset, line_reset;
   logic [3:0] video;
   logic [3:0] dbl_video;
   logic       dbl_hsync;

   cga_line_doubler #(.LINE_PIXELS(LP), .IN_DIV(DIV), .HS_START(HSS), .HS_WIDTH(HSW)) dut (
      .clk(clk), .reset(reset), .line_reset(line_reset), .video(video),
      .dbl_video(dbl_video), .dbl_hsync(dbl_hsync)
   );

   always #5 clk = ~clk;

   int         n_vec = 0, n_err = 0;
   int         cyc = 0, e = -1, prev_len = 0, cur_n = 0, line_no = 0;
   bit         armed = 0, const_f = 0;
   logic [3:0] prev_data [LP];
   logic [3:0] cur_data  [LP];
   logic [4:0] q[$];

   task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got={hs,vid}=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Expected {hsync,video} for the ocount state just after edge cyc.
   function automatic logic [4:0] model_now();
      int j, tot, idx;
      bit p1;
      logic [3:0] v;
      logic h;
      if (e < 0 || prev_len == 0) return 5'h0;
      j   = cyc - e;
      tot = j / HALF;
      if (tot < prev_len) begin idx = tot; p1 = 0; end
      else if (tot < 2 * prev_len) begin idx = tot - prev_len; p1 = 1; end
      else return 5'h0;
      v = prev_data[idx];
`ifdef CGA_DBL_SCANLINE_EN
      if (p1) v[3] = 1'b0;
`else
      if (p1) v = prev_data[idx];
`endif
      h = (idx >= HSS) && (idx < HSS + HSW);
      return {h, v};
   endfunction

   task automatic step(input bit lr, input bit rst);
      logic [3:0] v;
      if (const_f) v = 4'hF;
      else if (lr) v = 4'(((line_no + 1) * 3) % 16);
      else if (armed) v = 4'((((cyc + 1 - e) / DIV) + line_no * 3) % 16);
      else v = 4'($urandom_range(15));
      reset = rst; line_reset = lr; video = v;
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
         armed = 0; e = -1; prev_len = 0; cur_n = 0;
         q.delete();
         q.push_back(5'h0); q.push_back(5'h0);
      end else if (lr) begin
         prev_len = cur_n; prev_data = cur_data;
         cur_data[0] = v; cur_n = 1; e = cyc; armed = 1; line_no++;
      end else if (armed && ((cyc - e) % DIV == 0) && cur_n < LP) begin
         cur_data[cur_n] = v; cur_n++;
      end
      q.push_back(model_now());
      if (q.size() == 3) chk(rst ? "reset_out" : "dbl_out", {dbl_hsync, dbl_video}, q.pop_front());
   endtask

   task automatic line(input int n);
      step(1, 0);
      repeat (n - 1) step(0, 0);
   endtask

   initial begin
      reset = 1'b1; line_reset = 1'b0; video = 4'h0;
      for (int i = 0; i < LP; i++) begin prev_data[i] = 4'h0; cur_data[i] = 4'h0; end
      repeat (5) step(0, 1);
      chk("rst_vid", {1'b0, dbl_video}, 5'h0);
      chk("rst_hs", {4'h0, dbl_hsync}, 5'h0);
      repeat (2000) step(0, 0);
      line(3648);            // first line after reset: nothing to replay yet
      line(3648);
      line(3648);
      line(4800);            // 1200 pixels, saturates at LP
      line(3648);            // replays the saturated line
      line(3648);
      line(1924);            // cuts the next PASS1 100 clk in
      line(3648);
      repeat (8000) step(0, 0);
      step(1, 1);            // reset and line_reset together
      repeat (10) step(0, 0);
      line(400);
      line(400);
      repeat (2000) step(0, 0);
      const_f = 1;
      line(800);
      line(800);
      const_f = 0;
      repeat (4000) step(0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
